// File: rtl/mac_pkg.sv
// Shared definitions for the MAC dot-product sequencer.
//   mac_dot_state_e : sequencer FSM states
//   MAC_LAT         : pipeline depth of the downstream MAC; sets how many
//                     zero-operand cycles are spent draining before capture
//   DRAIN_W         : width of the drain counter sized from MAC_LAT
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        OUT
    } mac_dot_state_e;

    localparam int MAC_LAT = 2;
    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

endpackage

// File: rtl/mac_dot_ctrl.sv
// Upstream sequencer for a signed, pipelined MAC. Accepts a vector of operand
// pairs over valid/ready, clears the MAC at vector start, gates operands into
// it, waits out the MAC latency and presents the dot product over valid/ready.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start, len            begin a vector of len pairs (taken only when idle)
//   in_valid/in_ready     operand handshake, in_a/in_b signed operands
//   mac_clr, mac_a, mac_b drive the MAC (clear and operands)
//   mac_result            MAC accumulator
//   out_valid/out_ready   result handshake, out_data captured dot product
//   busy                  high whenever the sequencer is not idle
module mac_dot_ctrl
    import mac_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int VEC_LEN = 16,
    localparam int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mac_clr,
    output logic [WIDTH-1:0]   mac_a,
    output logic [WIDTH-1:0]   mac_b,
    input  logic [2*WIDTH-1:0] mac_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               busy
);

    mac_dot_state_e     state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_data_q, out_data_d;
    logic               fire;

    assign in_ready  = (state_q == RUN);
    assign fire      = in_valid && in_ready;
    // The MAC clears synchronously, so holding mac_clr during reset leaves it
    // empty once reset releases, discarding any aborted partial sum.
    assign mac_clr   = rst || (state_q == CLEAR);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        drain_d     = drain_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mac_a       = '0;
        mac_b       = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = (len > CNT_W'(VEC_LEN)) ? CNT_W'(VEC_LEN) : len;
                    if (len == '0) begin
                        // Empty vector: the dot product is zero, skip the MAC.
                        out_data_d  = '0;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end

            CLEAR: begin
                count_d = '0;
                state_d = RUN;
            end

            RUN: begin
                // Non-firing cycles feed zeros, which add nothing to the sum.
                if (fire) begin
                    mac_a   = in_a;
                    mac_b   = in_b;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == len_q - CNT_W'(1)) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // After MAC_LAT zero cycles the last product has reached the
                // accumulator, so capture on the final drain edge.
                if (drain_q == DRAIN_W'(MAC_LAT - 1)) begin
                    out_data_d  = mac_result;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end

            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values computed before this edge, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_q       <= '0;
            drain_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Testbench for mac_dot_ctrl with a behavioural 2-stage signed MAC beside it.
// Expected dot products come from plain integer sums over the stimulus arrays.
module tb_mac_dot_ctrl;

    localparam int WIDTH   = 8;
    localparam int VEC_LEN = 16;
    localparam int CNT_W   = $clog2(VEC_LEN + 1);

    logic               clk;
    logic               rst;
    logic               start;
    logic [CNT_W-1:0]   len;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               mac_clr;
    logic [WIDTH-1:0]   mac_a;
    logic [WIDTH-1:0]   mac_b;
    logic [2*WIDTH-1:0] mac_result;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_data;
    logic               busy;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;

    int va [32];
    int vb [32];
    int vg [32];

    mac_dot_ctrl #(.WIDTH(WIDTH), .VEC_LEN(VEC_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed MAC: product stage then accumulate stage, synchronous clear.
    logic signed [2*WIDTH-1:0] prod_q;
    logic signed [2*WIDTH-1:0] acc_q;
    always @(posedge clk) begin
        if (mac_clr) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= $signed(mac_a) * $signed(mac_b);
            acc_q  <= acc_q + prod_q;
        end
    end
    assign mac_result = acc_q;

    always @(posedge clk) if (mac_clr && !rst) clr_cnt <= clr_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one vector of n pairs from va/vb (vg[i] idle cycles before pair i),
    // holds out_ready low for `hold` cycles, optionally pulsing start while
    // waiting and during the output handshake.
    task automatic run_vec(input string tag, input int n, input int hold, input bit start_in_hold);
        int eff;
        int sum;
        int clr0;
        int budget;
        logic [15:0] exp;
        eff  = (n > VEC_LEN) ? VEC_LEN : n;
        sum  = 0;
        for (int i = 0; i < eff; i++) sum += va[i] * vb[i];
        exp  = sum[15:0];
        clr0 = clr_cnt;

        check({tag, "_idle_busy"}, busy, 0);
        start = 1'b1;
        len   = CNT_W'(n);
        step();
        start = 1'b0;
        len   = CNT_W'($urandom);

        if (eff == 0) begin
            check({tag, "_zero_outvalid"}, out_valid, 1);
            check({tag, "_zero_busy"}, busy, 1);
            check({tag, "_zero_noclr"}, clr_cnt, clr0);
        end else begin
            check({tag, "_clear_clr"}, mac_clr, 1);
            check({tag, "_clear_ready"}, in_ready, 0);
            for (int i = 0; i < eff; i++) begin
                for (int g = 0; g < vg[i]; g++) begin
                    in_valid = 1'b0;
                    in_a     = WIDTH'($urandom);
                    in_b     = WIDTH'($urandom);
                    #1;
                    if (i > 0) check({tag, "_gap_ready"}, in_ready, 1);
                    check({tag, "_gap_mac_a"}, mac_a, 0);
                    step();
                end
                in_valid = 1'b1;
                in_a     = WIDTH'(va[i]);
                in_b     = WIDTH'(vb[i]);
                #1;
                budget = 8;
                while (!in_ready && budget > 0) begin
                    step();
                    budget--;
                end
                check({tag, "_fire_ready"}, in_ready, 1);
                check({tag, "_pass_a"}, mac_a, in_a);
                check({tag, "_pass_b"}, mac_b, in_b);
                step();
            end
            in_valid = 1'b0;
            // Last fire was in cycle t; now in t+1. Result appears in t+3.
            check({tag, "_lat1"}, out_valid, 0);
            step();
            check({tag, "_lat2"}, out_valid, 0);
            check({tag, "_drain_busy"}, busy, 1);
            step();
            check({tag, "_lat3"}, out_valid, 1);
        end

        check({tag, "_data"}, out_data, exp);

        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = start_in_hold;
            len   = CNT_W'(1);
            step();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_data"}, out_data, exp);
            check({tag, "_hold_busy"}, busy, 1);
        end

        out_ready = 1'b1;
        start     = start_in_hold;
        len       = CNT_W'(1);
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_busy"}, busy, 0);
        step();
        check({tag, "_idle2_busy"}, busy, 0);
    endtask

    task automatic clear_vecs();
        for (int i = 0; i < 32; i++) begin
            va[i] = 0;
            vb[i] = 0;
            vg[i] = 0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        clear_vecs();
        repeat (3) step();

        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_busy", busy, 0);
        check("reset_mac_clr", mac_clr, 1);
        check("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        step();
        check("idle_mac_clr", mac_clr, 0);

        // 1: back-to-back pairs, result -21.
        clear_vecs();
        va[0] = 2;  vb[0] = 3;
        va[1] = -4; vb[1] = 5;
        va[2] = 7;  vb[2] = -1;
        run_vec("t1", 3, 0, 0);

        // 2: idle gap between pairs.
        clear_vecs();
        va[0] = 10;   vb[0] = 10;
        va[1] = -128; vb[1] = -128; vg[1] = 3;
        run_vec("t2", 2, 0, 0);

        // 3: empty vector.
        clear_vecs();
        run_vec("t3", 0, 0, 0);

        // 4: stalled output with start pulsed, including on the handshake.
        clear_vecs();
        va[0] = 5; vb[0] = 5;
        run_vec("t4", 1, 5, 1);

        // 5: reset after one of four pairs.
        clear_vecs();
        start = 1'b1;
        len   = CNT_W'(4);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = WIDTH'(7);
        in_b     = WIDTH'(9);
        step();
        check("t5_run_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_clr", mac_clr, 1);
        step();
        check("t5_rst_valid2", out_valid, 0);
        rst = 1'b0;
        step();
        va[0] = 3; vb[0] = 3;
        run_vec("t5", 1, 0, 0);
        check("t5_const", out_data, 16'd9);

        // 6: full-length vector whose sum wraps to zero.
        clear_vecs();
        for (int i = 0; i < 16; i++) begin
            va[i] = -128;
            vb[i] = -128;
        end
        run_vec("t6", 16, 1, 0);
        check("t6_const", out_data, 16'h0000);

        // Over-long len is clamped to VEC_LEN.
        clear_vecs();
        for (int i = 0; i < 16; i++) begin
            va[i] = 1;
            vb[i] = 1;
        end
        run_vec("clamp", 20, 0, 0);
        check("clamp_const", out_data, 16'd16);

        // Randomized vectors.
        for (int r = 0; r < 12; r++) begin
            int n;
            clear_vecs();
            n = $urandom_range(0, 20);
            for (int i = 0; i < 16; i++) begin
                va[i] = int'($urandom_range(0, 255)) - 128;
                vb[i] = int'($urandom_range(0, 255)) - 128;
                vg[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            run_vec("rand", n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
